// File: rtl/apb_i2c_regbank_v2_if.sv
// APB bus bundle between the interconnect and the I2C register bank.
interface apb_i2c_regbank_v2_if #(
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_regbank_v2.sv
// APB slave register bank for the I2C controller: registered access FSM with
// FIFO wait states and timeout, decode errors, and maskable sticky W1C interrupts.
module apb_i2c_regbank_v2 #(
    parameter int DATA_W   = 32,
    parameter int CFG_W    = 14,
    parameter int TO_W     = 14,
    parameter int WAIT_MAX = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_i2c_regbank_v2_if.slave   apb,
    input  logic [DATA_W-1:0]     READ_DATA_ON_RX,
    input  logic                  TX_FULL,
    input  logic                  TX_EMPTY,
    input  logic                  RX_EMPTY,
    input  logic                  ERROR,
    output logic [DATA_W-1:0]     WRITE_DATA_ON_TX,
    output logic                  WR_ENA,
    output logic                  RD_ENA,
    output logic [CFG_W-1:0]      I2C_CONFIG,
    output logic [TO_W-1:0]       I2C_TIMEOUT,
    output logic                  IRQ
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_tx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              access, dec_err, dec_tx, dec_rx;
    logic              go_tx, go_rx, go_reg, go_err;
    logic              pready_d, pslverr_d, wr_ena_d, rd_ena_d;
    logic [DATA_W-1:0] tx_src, rd_mux, prdata_q;
    logic              pready_q, pslverr_q;
    logic [2:0]        int_en, int_stat, int_evt, int_clr;
    logic              tx_empty_q, rx_empty_q, error_q;
    logic              reg_wr;

    // Returns {error, txdata_write, rxdata_read} for an access.
    function automatic logic [2:0] decode(input logic [31:0] addr, input logic wr);
        logic [2:0] r;
        case (addr)
            32'h00:                         r = wr ? 3'b010 : 3'b100;
            32'h04:                         r = wr ? 3'b100 : 3'b001;
            32'h08, 32'h0C, 32'h10, 32'h14: r = 3'b000;
            32'h18:                         r = wr ? 3'b100 : 3'b000;
            default:                        r = 3'b100;
        endcase
        return r;
    endfunction

    assign access = apb.PSELx & apb.PENABLE;
    assign {dec_err, dec_tx, dec_rx} = decode(apb.PADDR, apb.PWRITE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_tx_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && access) begin
                op_tx_q <= dec_tx;
                wdata_q <= apb.PWDATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_tx   = 1'b0;
        go_rx   = 1'b0;
        go_reg  = 1'b0;
        go_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    if (dec_err) begin
                        state_d = S_RESP;
                        go_err  = 1'b1;
                    end else if (dec_tx && !TX_FULL) begin
                        state_d = S_RESP;
                        go_tx   = 1'b1;
                    end else if (dec_rx && !RX_EMPTY) begin
                        state_d = S_RESP;
                        go_rx   = 1'b1;
                    end else if (dec_tx || dec_rx) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RESP;
                        go_reg  = 1'b1;
                    end
                end
            end
            // An abandoned transfer returns silently; a timeout fails without push/pop.
            S_WAIT: begin
                if (!apb.PSELx) begin
                    state_d = S_IDLE;
                end else if (op_tx_q && !TX_FULL) begin
                    state_d = S_RESP;
                    go_tx   = 1'b1;
                end else if (!op_tx_q && !RX_EMPTY) begin
                    state_d = S_RESP;
                    go_rx   = 1'b1;
                end else if (cnt_q == CNT_W'(WAIT_MAX - 1)) begin
                    state_d = S_RESP;
                    go_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pready_d  = (state_d == S_RESP);
        pslverr_d = go_err;
        wr_ena_d  = go_tx;
        rd_ena_d  = go_rx;
        tx_src    = (state_q == S_IDLE) ? apb.PWDATA : wdata_q;
    end

    always_comb begin
        rd_mux = '0;
        case (apb.PADDR)
            32'h08:  rd_mux = DATA_W'(I2C_CONFIG);
            32'h0C:  rd_mux = DATA_W'(I2C_TIMEOUT);
            32'h10:  rd_mux = DATA_W'(int_en);
            32'h14:  rd_mux = DATA_W'(int_stat);
            32'h18:  rd_mux = DATA_W'({ERROR, RX_EMPTY, TX_FULL, TX_EMPTY});
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_q         <= 1'b0;
            pslverr_q        <= 1'b0;
            WR_ENA           <= 1'b0;
            RD_ENA           <= 1'b0;
            WRITE_DATA_ON_TX <= '0;
            prdata_q         <= '0;
        end else begin
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            WR_ENA    <= wr_ena_d;
            RD_ENA    <= rd_ena_d;
            if (go_tx) WRITE_DATA_ON_TX <= tx_src;
            if (go_rx) prdata_q <= READ_DATA_ON_RX;
            else if (go_reg && !apb.PWRITE) prdata_q <= rd_mux;
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;

    assign reg_wr  = go_reg & apb.PWRITE;
    assign int_evt = {ERROR & ~error_q, ~RX_EMPTY & rx_empty_q, TX_EMPTY & ~tx_empty_q};
    assign int_clr = (reg_wr && apb.PADDR == 32'h14) ? apb.PWDATA[2:0] : 3'b000;

    // Event set wins over a simultaneous W1C clear of the same bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            I2C_CONFIG  <= '0;
            I2C_TIMEOUT <= '0;
            int_en      <= '0;
            int_stat    <= '0;
            tx_empty_q  <= 1'b1;
            rx_empty_q  <= 1'b1;
            error_q     <= 1'b0;
            IRQ         <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (apb.PADDR)
                    32'h08:  I2C_CONFIG  <= apb.PWDATA[CFG_W-1:0];
                    32'h0C:  I2C_TIMEOUT <= apb.PWDATA[TO_W-1:0];
                    32'h10:  int_en      <= apb.PWDATA[2:0];
                    default: ;
                endcase
            end
            tx_empty_q <= TX_EMPTY;
            rx_empty_q <= RX_EMPTY;
            error_q    <= ERROR;
            int_stat   <= (int_stat & ~int_clr) | int_evt;
            IRQ        <= |(int_stat & int_en);
        end
    end
endmodule

// File: tb/tb_apb_i2c_regbank_v2.sv
// Directed bench for apb_i2c_regbank_v2: register vector table plus FIFO, interrupt and reset sequences.
module tb_apb_i2c_regbank_v2;
    localparam int DATA_W = 32;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] READ_DATA_ON_RX;
    logic        TX_FULL, TX_EMPTY, RX_EMPTY, ERROR;
    logic [31:0] WRITE_DATA_ON_TX;
    logic        WR_ENA, RD_ENA;
    logic [13:0] I2C_CONFIG, I2C_TIMEOUT;
    logic        IRQ;

    int n_chk  = 0;
    int n_fail = 0;

    apb_i2c_regbank_v2_if #(.DATA_W(DATA_W)) bus();

    apb_i2c_regbank_v2 #(.DATA_W(DATA_W), .CFG_W(14), .TO_W(14), .WAIT_MAX(15)) dut (
        .PCLK             (PCLK),
        .PRESETn          (PRESETn),
        .apb              (bus),
        .READ_DATA_ON_RX  (READ_DATA_ON_RX),
        .TX_FULL          (TX_FULL),
        .TX_EMPTY         (TX_EMPTY),
        .RX_EMPTY         (RX_EMPTY),
        .ERROR            (ERROR),
        .WRITE_DATA_ON_TX (WRITE_DATA_ON_TX),
        .WR_ENA           (WR_ENA),
        .RD_ENA           (RD_ENA),
        .I2C_CONFIG       (I2C_CONFIG),
        .I2C_TIMEOUT      (I2C_TIMEOUT),
        .IRQ              (IRQ)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tab [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    // One APB transfer; rel_tx releases TX_FULL before access cycle rel_tx+1,
    // err_at raises ERROR at the start of that access cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int rel_tx, input int err_at,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nwr, output int nrd, output logic [31:0] txd);
        lat = 0; nwr = 0; nrd = 0; err = 1'b0; rdata = '0; txd = '0;
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (c == rel_tx + 1) TX_FULL = 1'b0;
            if (c == err_at) ERROR = 1'b1;
            @(negedge PCLK);
            if (WR_ENA) nwr++;
            if (RD_ENA) nrd++;
            if (bus.PREADY) begin
                lat = c; err = bus.PSLVERR; rdata = bus.PRDATA; txd = WRITE_DATA_ON_TX;
                break;
            end
            @(posedge PCLK); #1;
        end
        if (lat == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL xfer_timeout addr=0x%h: PREADY=0 after 40 cycles, expected PREADY=1", addr);
        end
        @(posedge PCLK); #1;
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK);
        if (WR_ENA) nwr++;
        if (RD_ENA) nrd++;
        chk("pready_one_cycle", {31'b0, bus.PREADY}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, txd;
        logic        err;
        int          lat, nwr, nrd, bad;

        bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        READ_DATA_ON_RX = '0; TX_FULL = 1'b0; TX_EMPTY = 1'b1; RX_EMPTY = 1'b1; ERROR = 1'b0;
        PRESETn = 1'b0;

        tab[0]  = '{1'b1, 32'h08, 32'h0000_3ABC, 1'b0, 1'b0, 32'h0};
        tab[1]  = '{1'b0, 32'h08, 32'h0,         1'b0, 1'b1, 32'h0000_3ABC};
        tab[2]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        tab[3]  = '{1'b0, 32'h0C, 32'h0,         1'b0, 1'b1, 32'h0000_3FFF};
        tab[4]  = '{1'b1, 32'h18, 32'h0000_1234, 1'b1, 1'b0, 32'h0};
        tab[5]  = '{1'b0, 32'h00, 32'h0,         1'b1, 1'b0, 32'h0};
        tab[6]  = '{1'b0, 32'h22, 32'h0,         1'b1, 1'b0, 32'h0};
        tab[7]  = '{1'b1, 32'h22, 32'h0000_5555, 1'b1, 1'b0, 32'h0};
        tab[8]  = '{1'b1, 32'h0A, 32'h0000_1111, 1'b1, 1'b0, 32'h0};
        tab[9]  = '{1'b1, 32'h04, 32'h0000_7777, 1'b1, 1'b0, 32'h0};
        tab[10] = '{1'b0, 32'h09, 32'h0,         1'b1, 1'b0, 32'h0};
        tab[11] = '{1'b0, 32'h08, 32'h0,         1'b0, 1'b1, 32'h0000_3ABC};
        tab[12] = '{1'b0, 32'h18, 32'h0,         1'b0, 1'b1, 32'h0000_0005};
        tab[13] = '{1'b0, 32'h10, 32'h0,         1'b0, 1'b1, 32'h0};
        tab[14] = '{1'b0, 32'h14, 32'h0,         1'b0, 1'b1, 32'h0};
        tab[15] = '{1'b1, 32'h08, 32'hFFFF_2001, 1'b0, 1'b0, 32'h0};
        tab[16] = '{1'b0, 32'h08, 32'h0,         1'b0, 1'b1, 32'h0000_2001};

        // Reset state
        #2;
        chk("rst_ctl", {27'b0, bus.PREADY, bus.PSLVERR, WR_ENA, RD_ENA, IRQ}, 32'h0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK) PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_cfg", {18'b0, I2C_CONFIG}, 32'h0);
        chk("rst_to", {18'b0, I2C_TIMEOUT}, 32'h0);
        chk("rst_outs", {29'b0, bus.PREADY, IRQ, WR_ENA}, 32'h0);

        // Register and decode vectors
        for (int i = 0; i < 17; i++) begin
            xfer(tab[i].wr, tab[i].addr, tab[i].wdata, -1, 0, rd, err, lat, nwr, nrd, txd);
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tab[i].exp_err});
            chk($sformatf("v%0d_lat", i), lat, 32'd2);
            chk($sformatf("v%0d_fifo", i), nwr + nrd, 32'd0);
            if (tab[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, tab[i].exp_rd);
        end
        chk("cfg_out", {18'b0, I2C_CONFIG}, 32'h0000_2001);
        chk("to_out", {18'b0, I2C_TIMEOUT}, 32'h0000_3FFF);

        // TX write stalled by TX_FULL for three cycles
        TX_FULL = 1'b1;
        xfer(1'b1, 32'h00, 32'h0000_00A5, 3, 0, rd, err, lat, nwr, nrd, txd);
        chk("tx_wait_lat", lat, 32'd5);
        chk("tx_wait_err", {31'b0, err}, 32'h0);
        chk("tx_wait_wr_ena", nwr, 32'd1);
        chk("tx_wait_rd_ena", nrd, 32'd0);
        chk("tx_wait_data", txd, 32'h0000_00A5);

        // RX read timing out on RX_EMPTY
        xfer(1'b0, 32'h04, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("rx_to_lat", lat, 32'd17);
        chk("rx_to_err", {31'b0, err}, 32'h1);
        chk("rx_to_rd_ena", nrd, 32'd0);

        // RX read with data available
        READ_DATA_ON_RX = 32'hDEAD_BEEF;
        RX_EMPTY = 1'b0;
        xfer(1'b0, 32'h04, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("rx_lat", lat, 32'd2);
        chk("rx_err", {31'b0, err}, 32'h0);
        chk("rx_rd_ena", nrd, 32'd1);
        chk("rx_data", rd, 32'hDEAD_BEEF);
        RX_EMPTY = 1'b1;
        xfer(1'b0, 32'h14, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("stat_rx_event", rd, 32'h2);
        xfer(1'b1, 32'h14, 32'h2, -1, 0, rd, err, lat, nwr, nrd, txd);
        xfer(1'b0, 32'h14, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("stat_w1c", rd, 32'h0);
        chk("irq_masked_rx", {31'b0, IRQ}, 32'h0);

        // ERROR interrupt, clear, and set-over-clear
        xfer(1'b1, 32'h10, 32'h4, -1, 0, rd, err, lat, nwr, nrd, txd);
        ERROR = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("irq_err_set", {31'b0, IRQ}, 32'h1);
        xfer(1'b0, 32'h14, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("stat_err_set", rd, 32'h4);
        ERROR = 1'b0;
        xfer(1'b1, 32'h14, 32'h4, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("irq_cleared", {31'b0, IRQ}, 32'h0);
        xfer(1'b1, 32'h14, 32'h4, -1, 1, rd, err, lat, nwr, nrd, txd);
        chk("w1c_race_err", {31'b0, err}, 32'h0);
        xfer(1'b0, 32'h14, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("stat_set_wins", rd, 32'h4);
        chk("irq_set_wins", {31'b0, IRQ}, 32'h1);
        xfer(1'b1, 32'h10, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("irq_mask", {31'b0, IRQ}, 32'h0);
        xfer(1'b0, 32'h14, 32'h0, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("stat_kept_masked", rd, 32'h4);
        ERROR = 1'b0;

        // Master abandons a stalled TX write
        TX_FULL = 1'b1;
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'h5A;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
        TX_FULL = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (WR_ENA || bus.PREADY) bad++;
        end
        chk("abort_quiet", bad, 32'd0);
        chk("abort_txdata", WRITE_DATA_ON_TX, 32'h0000_00A5);

        // Reset asserted while waiting on TX_FULL
        TX_FULL = 1'b1;
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'h3C;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        #1;
        chk("rst_wait_ctl", {29'b0, bus.PREADY, WR_ENA, RD_ENA}, 32'h0);
        chk("rst_wait_cfg", {18'b0, I2C_CONFIG}, 32'h0);
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
        TX_FULL = 1'b0;
        @(negedge PCLK) PRESETn = 1'b1;
        xfer(1'b1, 32'h08, 32'h0000_0123, -1, 0, rd, err, lat, nwr, nrd, txd);
        chk("post_rst_lat", lat, 32'd2);
        chk("post_rst_fifo", nwr + nrd, 32'd0);

        // Reset asserted during the WR_ENA response cycle
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h00; bus.PWDATA = 32'h77;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("resp_wr_ena", {30'b0, WR_ENA, bus.PREADY}, 32'h3);
        #1 PRESETn = 1'b0;
        #1;
        chk("rst_resp_ctl", {29'b0, bus.PREADY, WR_ENA, RD_ENA}, 32'h0);
        chk("rst_resp_txdata", WRITE_DATA_ON_TX, 32'h0);
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0;
        @(negedge PCLK) PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_i2c_regbank_v2.md
Name: apb_i2c_regbank_v2

Overview:
- Parametrised APB slave register bank for the I2C controller.
- Replaces the purely combinational bridge with a registered access FSM.
- Adds FIFO-aware wait states with a bounded timeout, PSLVERR decode errors, and maskable sticky interrupts with write-1-to-clear.
- Sits between the APB interconnect and the I2C core's TX/RX FIFOs and configuration inputs.

Parameters:
- DATA_W, 32, APB data width and FIFO data width.
- CFG_W, 14, width of the CONFIG register.
- TO_W, 14, width of the TIMEOUT register.
- WAIT_MAX, 15, maximum wait cycles before a FIFO access fails with PSLVERR (must be ≥1).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSELx, PENABLE, PWRITE  in  1 each  APB controls.
- PADDR  in  32  byte address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  registered read data.
- PREADY  out  1  registered.
- PSLVERR  out  1  registered.
- READ_DATA_ON_RX  in  DATA_W  RX FIFO head (first-word-fall-through).
- TX_FULL, TX_EMPTY, RX_EMPTY, ERROR  in  1 each  core status.
- WRITE_DATA_ON_TX  out  DATA_W  registered TX data.
- WR_ENA, RD_ENA  out  1 each  single-cycle FIFO push/pop.
- I2C_CONFIG  out  CFG_W  configuration register.
- I2C_TIMEOUT  out  TO_W  timeout register.
- IRQ  out  1  registered interrupt request.

Behaviour:
- Reset: asynchronous, active-low (PRESETn). While PRESETn=0, every output is 0 and the FSM is IDLE. This applies mid-transaction: any pending WR_ENA/RD_ENA is discarded.
- Address map (offsets):
  - 0x00 TXDATA, W.
  - 0x04 RXDATA, R.
  - 0x08 CONFIG, RW.
  - 0x0C TIMEOUT, RW.
  - 0x10 INT_EN[2:0], RW.
  - 0x14 INT_STAT[2:0], R / W1C.
  - 0x18 STATUS, RO = {28'b0, ERROR, RX_EMPTY, TX_FULL, TX_EMPTY}.
- Decode error: PSLVERR=1 and no side effects for any of:
  - unmapped offset;
  - PADDR[1:0]≠0;
  - write to 0x04 or 0x18;
  - read of 0x00.
- Unused read bits return 0. Register writes use PWDATA low bits.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on PSELx&PENABLE, decode.
    - Decode error or non-FIFO register → RESP.
    - TXDATA write with TX_FULL=0, or RXDATA read with RX_EMPTY=0 → RESP.
    - Otherwise → WAIT, with wait counter cleared.
  - WAIT: counter increments each cycle.
    - Condition met → RESP.
    - Counter reaches WAIT_MAX → RESP with error (no push/pop).
    - PSELx=0 → IDLE with no response and no side effects.
  - RESP: PREADY=1 for exactly one cycle, PSLVERR per outcome, then unconditionally → IDLE.
- RESP-cycle actions for a successful access:
  - FIFO access: WR_ENA=1 (with WRITE_DATA_ON_TX=captured PWDATA) or RD_ENA=1 in the RESP cycle.
  - Register write: updates on the edge entering RESP.
  - PRDATA: loaded on the edge entering RESP (RXDATA from READ_DATA_ON_RX) and held until the next read.
- Latency: minimum one wait state, i.e. PREADY rises in the 2nd access cycle. Worst case is WAIT_MAX+2 cycles.
- Interrupt status bits are sticky, set on detected edges using registered copies of the inputs:
  - bit0: TX_EMPTY 0→1.
  - bit1: RX_EMPTY 1→0.
  - bit2: ERROR 0→1.
- W1C write to 0x14 clears the bits written as 1. Set has priority over a simultaneous clear.
- IRQ = |(INT_STAT & INT_EN), registered with one-cycle delay. Clearing INT_EN masks IRQ without altering INT_STAT.
- Edge detectors are reset to TX_EMPTY=1, RX_EMPTY=1, ERROR=0, so no spurious event fires on reset release with idle inputs.

Test Plan:
- Write 0x08 data 0x3ABC, then read 0x08 → I2C_CONFIG=0x3ABC, read returns 0x00003ABC. PREADY is high in the 2nd access cycle, PSLVERR=0.
- Write 0x00 data 0xA5 with TX_FULL=1, releasing TX_FULL after 3 cycles → PREADY is delayed 3 cycles, then WR_ENA is a 1-cycle pulse with WRITE_DATA_ON_TX=0xA5.
- Read 0x04 with RX_EMPTY=1 held → after WAIT_MAX=15 waits PREADY=1, PSLVERR=1, RD_ENA never asserted.
- Write 0x18, read 0x00, and access 0x22 → each gives PSLVERR=1, no register change, no FIFO pulse.
- INT_EN=0b100; pulse ERROR 0→1 → INT_STAT[2]=1 and IRQ=1. Write 0x14 with 0b100 → IRQ=0. A simultaneous ERROR edge during the clear keeps the bit at 1.
- Assert PRESETn=0 while in WAIT → PREADY, WR_ENA and RD_ENA go 0 immediately; after release, CONFIG=0 and the FSM is IDLE.
